// File: rtl/sti_rx.sv
// sti_rx: serial-to-parallel receiver.
// Turns framed serial bits into a 16-bit parallel word and writes every
// received byte to pixel memory. A frame flagged as the last one pads the
// rest of the memory with zeros and then parks the block in FINISH.
module sti_rx (
    input  logic        clk,
    input  logic        reset,
    input  logic        si_data,
    input  logic        si_valid,
    input  logic [1:0]  si_length,
    input  logic        si_msb,
    input  logic        si_fill,
    input  logic        si_low,
    input  logic        si_end,
    output logic [15:0] po_data,
    output logic        po_valid,
    output logic        frame_err,
    output logic        pixel_wr,
    output logic [7:0]  pixel_addr,
    output logic [7:0]  pixel_dataout,
    output logic        pixel_finish
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RECV   = 3'd1;
    localparam logic [2:0] DONE   = 3'd2;
    localparam logic [2:0] FILL   = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [5:0]  bit_cnt;
    logic [1:0]  cfg_len;
    logic        cfg_msb;
    logic        cfg_fill;
    logic        cfg_low;
    logic [31:0] word;
    logic [7:0]  byte_sr;
    logic [7:0]  wr_ptr;

    logic        frame_start;
    logic        bit_take;
    logic        frame_abort;
    logic [1:0]  cur_len;
    logic        cur_msb;
    logic        cur_fill;
    logic        cur_low;
    logic [5:0]  cur_k;
    logic [5:0]  cnt_next;
    logic [5:0]  frame_bits;
    logic [4:0]  bit_idx;
    logic        last_bit;
    logic        byte_done;
    logic        fill_write;
    logic [31:0] word_next;
    logic [7:0]  byte_next;
    logic [15:0] extracted;

    // A new frame may begin in IDLE or right after a completed frame in DONE.
    assign frame_start = ((state == IDLE) || (state == DONE)) && si_valid;
    assign bit_take    = frame_start || ((state == RECV) && si_valid);
    assign frame_abort = (state == RECV) && !si_valid;

    // On the first bit the configuration comes straight from the inputs.
    assign cur_len  = frame_start ? si_length : cfg_len;
    assign cur_msb  = frame_start ? si_msb    : cfg_msb;
    assign cur_fill = frame_start ? si_fill   : cfg_fill;
    assign cur_low  = frame_start ? si_low    : cfg_low;
    assign cur_k    = frame_start ? 6'd0      : bit_cnt;
    assign cnt_next = cur_k + 6'd1;

    assign frame_bits = ({4'd0, cur_len} + 6'd1) << 3;
    assign bit_idx    = cur_msb ? 5'(frame_bits - 6'd1 - cur_k) : cur_k[4:0];
    assign last_bit   = bit_take && (cnt_next == frame_bits);
    assign byte_done  = bit_take && (cur_k[2:0] == 3'd7);
    assign fill_write = (state == FILL) && (wr_ptr != 8'd0);

    // Byte shifter keeps the first-received bit at bit 7 (MSB-first) or bit 0 (LSB-first).
    assign byte_next = cur_msb ? {byte_sr[6:0], si_data} : {si_data, byte_sr[7:1]};

    // Place the incoming bit into the word being assembled; a new frame starts from zero.
    always_comb begin
        word_next = frame_start ? 32'd0 : word;
        word_next[bit_idx] = si_data;
    end

    // Pick the 16-bit payload out of the completed word, including the current last bit.
    always_comb begin
        extracted = word_next[15:0];
        case (cur_len)
            2'd0:    extracted = cur_low ? {word_next[7:0], 8'h00} : {8'h00, word_next[7:0]};
            2'd1:    extracted = word_next[15:0];
            2'd2:    extracted = cur_fill ? word_next[23:8] : word_next[15:0];
            2'd3:    extracted = cur_fill ? word_next[31:16] : word_next[15:0];
            default: extracted = word_next[15:0];
        endcase
    end

    // Next-state logic for frame reception, memory padding and the terminal state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (si_valid) state_next = RECV;
            end
            RECV: begin
                if (!si_valid)     state_next = IDLE;
                else if (last_bit) state_next = si_end ? FILL : DONE;
            end
            DONE: begin
                state_next = si_valid ? RECV : IDLE;
            end
            FILL: begin
                if (wr_ptr == 8'd0) state_next = FINISH;
            end
            FINISH: begin
                state_next = FINISH;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Frame datapath: configuration latch, word and byte assembly, bit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_len  <= 2'd0;
            cfg_msb  <= 1'b0;
            cfg_fill <= 1'b0;
            cfg_low  <= 1'b0;
            word     <= 32'd0;
            byte_sr  <= 8'd0;
            bit_cnt  <= 6'd0;
        end else begin
            if (frame_start) begin
                cfg_len  <= si_length;
                cfg_msb  <= si_msb;
                cfg_fill <= si_fill;
                cfg_low  <= si_low;
            end
            if (bit_take) begin
                word    <= word_next;
                byte_sr <= byte_next;
                bit_cnt <= last_bit ? 6'd0 : cnt_next;
            end else if (frame_abort) begin
                bit_cnt <= 6'd0;
            end
        end
    end

    // Registered outputs: word and error pulses, byte writes and zero-padding writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            po_data       <= 16'd0;
            po_valid      <= 1'b0;
            frame_err     <= 1'b0;
            pixel_wr      <= 1'b0;
            pixel_addr    <= 8'd0;
            pixel_dataout <= 8'd0;
            wr_ptr        <= 8'd0;
        end else begin
            po_valid  <= last_bit;
            frame_err <= frame_abort;
            pixel_wr  <= 1'b0;
            if (last_bit) po_data <= extracted;
            if (byte_done) begin
                pixel_wr      <= 1'b1;
                pixel_addr    <= wr_ptr;
                pixel_dataout <= byte_next;
                wr_ptr        <= wr_ptr + 8'd1;
            end else if (fill_write) begin
                pixel_wr      <= 1'b1;
                pixel_addr    <= wr_ptr;
                pixel_dataout <= 8'h00;
                wr_ptr        <= wr_ptr + 8'd1;
            end
        end
    end

    assign pixel_finish = (state == FINISH);

endmodule

// File: tb/tb_sti_rx.sv
// tb_sti_rx: directed self-checking bench for sti_rx.
`timescale 1ns/1ps
module tb_sti_rx;

    logic        clk;
    logic        reset;
    logic        si_data;
    logic        si_valid;
    logic [1:0]  si_length;
    logic        si_msb;
    logic        si_fill;
    logic        si_low;
    logic        si_end;
    logic [15:0] po_data;
    logic        po_valid;
    logic        frame_err;
    logic        pixel_wr;
    logic [7:0]  pixel_addr;
    logic [7:0]  pixel_dataout;
    logic        pixel_finish;

    int errors = 0;
    int checks = 0;

    logic [7:0]  wrAddr[$];
    logic [7:0]  wrData[$];
    time         wrTime[$];
    logic [15:0] pvData[$];
    time         pvTime[$];
    int          errCount;

    sti_rx dut (
        .clk(clk),
        .reset(reset),
        .si_data(si_data),
        .si_valid(si_valid),
        .si_length(si_length),
        .si_msb(si_msb),
        .si_fill(si_fill),
        .si_low(si_low),
        .si_end(si_end),
        .po_data(po_data),
        .po_valid(po_valid),
        .frame_err(frame_err),
        .pixel_wr(pixel_wr),
        .pixel_addr(pixel_addr),
        .pixel_dataout(pixel_dataout),
        .pixel_finish(pixel_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every write, word pulse and error pulse, sampled away from the rising edge.
    always @(negedge clk) begin
        if (pixel_wr) begin
            wrAddr.push_back(pixel_addr);
            wrData.push_back(pixel_dataout);
            wrTime.push_back($time);
        end
        if (po_valid) begin
            pvData.push_back(po_data);
            pvTime.push_back($time);
        end
        if (frame_err) errCount++;
    end

    // Hard stop in case something hangs.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearLogs();
        wrAddr.delete();
        wrData.delete();
        wrTime.delete();
        pvData.delete();
        pvTime.delete();
        errCount = 0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        si_valid = 1'b0;
        si_data = 1'b0;
        si_end = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        clearLogs();
    endtask

    task automatic applyStimulus(input logic [1:0] len, input logic msb, input logic fill,
                                 input logic low, input logic endf, input logic [31:0] data,
                                 input int nsend, input bit hold, output time lastT);
        int n;
        n = (int'(len) + 1) * 8;
        lastT = 0;
        for (int k = 0; k < nsend; k++) begin
            @(negedge clk);
            si_valid  = 1'b1;
            si_length = len;
            si_msb    = msb;
            si_fill   = fill;
            si_low    = low;
            si_data   = msb ? data[n - 1 - k] : data[k];
            si_end    = endf && (k == n - 1);
            lastT     = $time;
        end
        if (!hold) begin
            @(negedge clk);
            si_valid = 1'b0;
            si_data  = 1'b0;
            si_end   = 1'b0;
        end
    endtask

    task automatic waitFinish(input int budget, output time tFin);
        tFin = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (pixel_finish) begin
                tFin = $time;
                break;
            end
        end
        #1;
    endtask

    initial begin
        time t0;
        time t1;
        time tFin;
        int  bad;

        reset = 1'b1;
        si_data = 1'b0;
        si_valid = 1'b0;
        si_length = 2'd0;
        si_msb = 1'b0;
        si_fill = 1'b0;
        si_low = 1'b0;
        si_end = 1'b0;
        errCount = 0;
        #1 reset = 1'b0;
        #3;
        checkOutput("rst_po_data", 32'(po_data), 32'h0);
        checkOutput("rst_po_valid", 32'(po_valid), 32'h0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
        checkOutput("rst_pixel_wr", 32'(pixel_wr), 32'h0);
        checkOutput("rst_pixel_addr", 32'(pixel_addr), 32'h0);
        checkOutput("rst_pixel_dataout", 32'(pixel_dataout), 32'h0);
        checkOutput("rst_pixel_finish", 32'(pixel_finish), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        clearLogs();

        // 16-bit MSB-first frame
        $display("[TB] 16-bit MSB-first frame");
        applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000A5C3, 16, 1'b0, t0);
        settle();
        checkOutput("a5c3_nwr", 32'(wrAddr.size()), 32'd2);
        if (wrAddr.size() >= 2) begin
            checkOutput("a5c3_addr0", 32'(wrAddr[0]), 32'h00);
            checkOutput("a5c3_data0", 32'(wrData[0]), 32'hA5);
            checkOutput("a5c3_addr1", 32'(wrAddr[1]), 32'h01);
            checkOutput("a5c3_data1", 32'(wrData[1]), 32'hC3);
            checkOutput("a5c3_wr_time", 32'(wrTime[1] - t0), 32'd10);
        end
        checkOutput("a5c3_npv", 32'(pvData.size()), 32'd1);
        if (pvData.size() >= 1) begin
            checkOutput("a5c3_po_data", 32'(pvData[0]), 32'hA5C3);
            checkOutput("a5c3_pv_time", 32'(pvTime[0] - t0), 32'd10);
        end
        checkOutput("a5c3_po_hold", 32'(po_data), 32'hA5C3);

        // 8-bit LSB-first frame into the upper byte
        $display("[TB] 8-bit LSB-first low frame");
        doReset();
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000005A, 8, 1'b0, t0);
        settle();
        checkOutput("5a_nwr", 32'(wrAddr.size()), 32'd1);
        if (wrAddr.size() >= 1) begin
            checkOutput("5a_addr", 32'(wrAddr[0]), 32'h00);
            checkOutput("5a_data", 32'(wrData[0]), 32'h5A);
        end
        checkOutput("5a_npv", 32'(pvData.size()), 32'd1);
        if (pvData.size() >= 1) checkOutput("5a_po_data", 32'(pvData[0]), 32'h5A00);

        // 32-bit frame with upper payload
        $display("[TB] 32-bit fill frame");
        doReset();
        applyStimulus(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12340000, 32, 1'b0, t0);
        settle();
        checkOutput("32b_nwr", 32'(wrAddr.size()), 32'd4);
        if (wrAddr.size() >= 4) begin
            checkOutput("32b_data0", 32'(wrData[0]), 32'h12);
            checkOutput("32b_data1", 32'(wrData[1]), 32'h34);
            checkOutput("32b_data2", 32'(wrData[2]), 32'h00);
            checkOutput("32b_addr3", 32'(wrAddr[3]), 32'h03);
        end
        if (pvData.size() >= 1) checkOutput("32b_po_data", 32'(pvData[0]), 32'h1234);
        else checkOutput("32b_npv", 32'(pvData.size()), 32'd1);

        // Two back-to-back 24-bit frames, lower then upper payload
        $display("[TB] back-to-back 24-bit frames");
        doReset();
        applyStimulus(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00ABCDEF, 24, 1'b1, t0);
        applyStimulus(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0013579B, 24, 1'b0, t1);
        settle();
        checkOutput("24b_nwr", 32'(wrAddr.size()), 32'd6);
        if (wrAddr.size() >= 6) begin
            checkOutput("24b_data0", 32'(wrData[0]), 32'hEF);
            checkOutput("24b_data2", 32'(wrData[2]), 32'hAB);
            checkOutput("24b_data3", 32'(wrData[3]), 32'h13);
            checkOutput("24b_data5", 32'(wrData[5]), 32'h9B);
            checkOutput("24b_addr5", 32'(wrAddr[5]), 32'h05);
        end
        checkOutput("24b_npv", 32'(pvData.size()), 32'd2);
        if (pvData.size() >= 2) begin
            checkOutput("24b_po_data0", 32'(pvData[0]), 32'hCDEF);
            checkOutput("24b_po_data1", 32'(pvData[1]), 32'h1357);
            checkOutput("24b_pv_time1", 32'(pvTime[1] - t1), 32'd10);
        end

        // Aborted frame
        $display("[TB] aborted frame");
        doReset();
        applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000011, 8, 1'b0, t0);
        settle();
        applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000000FF, 5, 1'b0, t0);
        settle();
        checkOutput("abort_err_cnt", 32'(errCount), 32'd1);
        checkOutput("abort_nwr", 32'(wrAddr.size()), 32'd1);
        checkOutput("abort_npv", 32'(pvData.size()), 32'd1);
        checkOutput("abort_po_hold", 32'(po_data), 32'h0011);
        applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000022, 8, 1'b0, t0);
        settle();
        checkOutput("abort_next_nwr", 32'(wrAddr.size()), 32'd2);
        if (wrAddr.size() >= 2) begin
            checkOutput("abort_next_addr", 32'(wrAddr[1]), 32'h01);
            checkOutput("abort_next_data", 32'(wrData[1]), 32'h22);
        end
        checkOutput("abort_next_err_cnt", 32'(errCount), 32'd1);

        // Last frame followed by zero padding to the end of memory
        $display("[TB] fill after last frame");
        doReset();
        applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000102, 16, 1'b0, t0);
        applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000304, 16, 1'b0, t1);
        waitFinish(400, tFin);
        checkOutput("fill_finish", 32'(pixel_finish), 32'h1);
        checkOutput("fill_finish_time", 32'(tFin - t1), 32'd2540);
        checkOutput("fill_nwr", 32'(wrAddr.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < wrAddr.size(); i++) begin
            if (wrAddr[i] != 8'(i)) bad++;
            if (wrData[i] != ((i < 4) ? 8'(i + 1) : 8'h00)) bad++;
        end
        checkOutput("fill_content_bad", 32'(bad), 32'd0);
        if (wrAddr.size() == 256) checkOutput("fill_zero_span", 32'(wrTime[255] - wrTime[3]), 32'd2520);
        applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000000AA, 8, 1'b0, t0);
        settle();
        checkOutput("finish_ignore_nwr", 32'(wrAddr.size()), 32'd256);
        checkOutput("finish_ignore_npv", 32'(pvData.size()), 32'd2);
        checkOutput("finish_hold", 32'(pixel_finish), 32'h1);

        // Last byte lands on address 255: no zero writes
        $display("[TB] last byte at top of memory");
        doReset();
        for (int f = 0; f < 128; f++) begin
            applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, (f == 127), {16'h0, 8'(2 * f), 8'(2 * f + 1)},
                          16, 1'b0, t1);
        end
        waitFinish(20, tFin);
        checkOutput("wrap_finish", 32'(pixel_finish), 32'h1);
        checkOutput("wrap_finish_time", 32'(tFin - t1), 32'd20);
        checkOutput("wrap_nwr", 32'(wrAddr.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < wrAddr.size(); i++) begin
            if (wrAddr[i] != 8'(i)) bad++;
            if (wrData[i] != 8'(i)) bad++;
        end
        checkOutput("wrap_content_bad", 32'(bad), 32'd0);

        // Reset in the middle of a 24-bit frame
        $display("[TB] reset during frame");
        doReset();
        applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000003C, 8, 1'b0, t0);
        settle();
        applyStimulus(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00FFFFFF, 10, 1'b1, t0);
        @(posedge clk);
        #2;
        checkOutput("midrst_pre_addr", 32'(pixel_addr), 32'h01);
        checkOutput("midrst_pre_data", 32'(pixel_dataout), 32'hFF);
        checkOutput("midrst_pre_po", 32'(po_data), 32'h003C);
        reset = 1'b0;
        #1;
        checkOutput("midrst_po_data", 32'(po_data), 32'h0);
        checkOutput("midrst_pixel_addr", 32'(pixel_addr), 32'h0);
        checkOutput("midrst_pixel_dataout", 32'(pixel_dataout), 32'h0);
        checkOutput("midrst_pixel_wr", 32'(pixel_wr), 32'h0);
        checkOutput("midrst_po_valid", 32'(po_valid), 32'h0);
        checkOutput("midrst_frame_err", 32'(frame_err), 32'h0);
        checkOutput("midrst_finish", 32'(pixel_finish), 32'h0);
        @(negedge clk);
        si_valid = 1'b0;
        si_data = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        clearLogs();
        applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000000FF, 8, 1'b0, t0);
        settle();
        checkOutput("postrst_nwr", 32'(wrAddr.size()), 32'd1);
        if (wrAddr.size() >= 1) begin
            checkOutput("postrst_addr", 32'(wrAddr[0]), 32'h00);
            checkOutput("postrst_data", 32'(wrData[0]), 32'hFF);
        end
        checkOutput("postrst_po_data", 32'(po_data), 32'h00FF);
        checkOutput("postrst_err_cnt", 32'(errCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
